// File: rtl/pc_sequencer.sv
// Program-counter sequencing FSM: picks next_pc, drives the PC hold and IF/ID flush,
// and keeps running/stalled cycle counters.
module pc_sequencer #(
  parameter int                   WORD_SIZE    = 32,
  parameter logic [WORD_SIZE-1:0] RESET_VECTOR = {WORD_SIZE{1'b0}},
  parameter int                   MUL_STALL    = 4,
  parameter int                   CNT_W        = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] pc_out,
  input  logic                 jump,
  input  logic [WORD_SIZE-1:0] jump_target,
  input  logic                 branch_taken,
  input  logic [WORD_SIZE-1:0] branch_target,
  input  logic                 hazard_stall,
  input  logic                 mul_start,
  input  logic                 syscall_halt,
  input  logic                 resume,
  output logic [WORD_SIZE-1:0] next_pc,
  output logic                 pc_halt,
  output logic                 flush,
  output logic [1:0]           state,
  output logic [CNT_W-1:0]     cycle_count,
  output logic [CNT_W-1:0]     stall_count
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MULWAIT = 2'd1,
    HALTED  = 2'd2
  } state_t;

  localparam int                   MUL_W   = $clog2(MUL_STALL + 1);
  localparam logic [WORD_SIZE-1:0] PC_STEP = WORD_SIZE'(32'd4);
  localparam logic [MUL_W-1:0]     MUL_LD  = MUL_W'(MUL_STALL);
  localparam logic [MUL_W-1:0]     MUL_ONE = MUL_W'(1'b1);
  localparam logic [CNT_W-1:0]     CNT_ONE = CNT_W'(1'b1);

  state_t                 state_r;
  state_t                 next_state_s;
  logic [MUL_W-1:0]       mul_cnt_r;
  logic [MUL_W-1:0]       mul_cnt_nxt_s;
  logic [CNT_W-1:0]       cycle_count_r;
  logic [CNT_W-1:0]       stall_count_r;
  logic [WORD_SIZE-1:0]   next_pc_s;
  logic                   pc_halt_s;
  logic                   flush_s;

  // Next-state and PC selection; RUN resolves requests by fixed priority.
  always_comb begin
    next_state_s  = state_r;
    mul_cnt_nxt_s = mul_cnt_r;
    next_pc_s     = pc_out;
    pc_halt_s     = 1'b1;
    flush_s       = 1'b0;
    case (state_r)
      RUN: begin
        if (syscall_halt) begin
          next_state_s = HALTED;
        end else if (jump) begin
          next_pc_s = jump_target;
          pc_halt_s = 1'b0;
          flush_s   = 1'b1;
        end else if (branch_taken) begin
          next_pc_s = branch_target;
          pc_halt_s = 1'b0;
          flush_s   = 1'b1;
        end else if (hazard_stall) begin
          pc_halt_s = 1'b1;
        end else if (mul_start) begin
          next_pc_s     = pc_out + PC_STEP;
          pc_halt_s     = 1'b0;
          mul_cnt_nxt_s = MUL_LD;
          next_state_s  = MULWAIT;
        end else begin
          next_pc_s = pc_out + PC_STEP;
          pc_halt_s = 1'b0;
        end
      end
      MULWAIT: begin
        // <= also catches a zero count so the FSM can never stick here
        if (mul_cnt_r <= MUL_ONE) begin
          mul_cnt_nxt_s = {MUL_W{1'b0}};
          next_state_s  = RUN;
        end else begin
          mul_cnt_nxt_s = mul_cnt_r - MUL_ONE;
        end
      end
      HALTED: begin
        if (resume) begin
          next_state_s = RUN;
        end else begin
          next_state_s = HALTED;
        end
      end
      default: begin
        next_state_s  = RUN;
        mul_cnt_nxt_s = {MUL_W{1'b0}};
      end
    endcase
  end

  // Reset forces the PC register toward the reset vector and holds it.
  always_comb begin
    if (!rst) begin
      next_pc = RESET_VECTOR;
      pc_halt = 1'b1;
      flush   = 1'b0;
    end else begin
      next_pc = next_pc_s;
      pc_halt = pc_halt_s;
      flush   = flush_s;
    end
  end

  // State, multiply countdown and performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= RUN;
      mul_cnt_r     <= {MUL_W{1'b0}};
      cycle_count_r <= {CNT_W{1'b0}};
      stall_count_r <= {CNT_W{1'b0}};
    end else begin
      state_r   <= next_state_s;
      mul_cnt_r <= mul_cnt_nxt_s;
      if (!pc_halt_s) begin
        cycle_count_r <= cycle_count_r + CNT_ONE;
      end else if (state_r != HALTED) begin
        stall_count_r <= stall_count_r + CNT_ONE;
      end else begin
        stall_count_r <= stall_count_r;
      end
    end
  end

  assign state       = state_r;
  assign cycle_count = cycle_count_r;
  assign stall_count = stall_count_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; inputs change on the falling edge
// and outputs are sampled 1 time unit later.
module tb_pc_sequencer;

  localparam int          WS    = 32;
  localparam int          CW    = 8;
  localparam logic [31:0] RVEC  = 32'h0000_1000;

  logic          clk;
  logic          rst;
  logic [WS-1:0] pc_out;
  logic          jump;
  logic [WS-1:0] jump_target;
  logic          branch_taken;
  logic [WS-1:0] branch_target;
  logic          hazard_stall;
  logic          mul_start;
  logic          syscall_halt;
  logic          resume;
  logic [WS-1:0] next_pc;
  logic          pc_halt;
  logic          flush;
  logic [1:0]    state;
  logic [CW-1:0] cycle_count;
  logic [CW-1:0] stall_count;

  int checks   = 0;
  int failures = 0;

  pc_sequencer #(
    .WORD_SIZE    (WS),
    .RESET_VECTOR (RVEC),
    .MUL_STALL    (4),
    .CNT_W        (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_out        (pc_out),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .hazard_stall  (hazard_stall),
    .mul_start     (mul_start),
    .syscall_halt  (syscall_halt),
    .resume        (resume),
    .next_pc       (next_pc),
    .pc_halt       (pc_halt),
    .flush         (flush),
    .state         (state),
    .cycle_count   (cycle_count),
    .stall_count   (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    jump          = 1'b0;
    jump_target   = 32'h0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    hazard_stall  = 1'b0;
    mul_start     = 1'b0;
    syscall_halt  = 1'b0;
    resume        = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst    = 1'b1;
    pc_out = 32'h0;
    clear_inputs();

    // Reset state and forced outputs
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("rst_state",  64'(state),       64'd0);
    check_val("rst_cycle",  64'(cycle_count), 64'd0);
    check_val("rst_stall",  64'(stall_count), 64'd0);
    check_val("rst_nextpc", 64'(next_pc),     64'(RVEC));
    check_val("rst_halt",   64'(pc_halt),     64'd1);
    check_val("rst_flush",  64'(flush),       64'd0);
    @(negedge clk);
    rst = 1'b1;

    // 1: sequential free-run
    for (int i = 0; i < 5; i++) begin
      pc_out = 32'(4 * i);
      #1;
      check_val("seq_nextpc", 64'(next_pc), 64'(4 * (i + 1)));
      check_val("seq_halt",   64'(pc_halt), 64'd0);
      check_val("seq_flush",  64'(flush),   64'd0);
      @(negedge clk);
    end
    check_val("seq_cycle", 64'(cycle_count), 64'd5);
    check_val("seq_stall", 64'(stall_count), 64'd0);

    // 2: jump beats branch
    pc_out = 32'h40; jump = 1'b1; jump_target = 32'h100;
    branch_taken = 1'b1; branch_target = 32'h80;
    #1;
    check_val("jmp_nextpc", 64'(next_pc), 64'h100);
    check_val("jmp_flush",  64'(flush),   64'd1);
    check_val("jmp_halt",   64'(pc_halt), 64'd0);
    @(negedge clk);
    clear_inputs();
    pc_out = 32'h100;
    #1;
    check_val("jmp_flush_end", 64'(flush),   64'd0);
    check_val("jmp_after_pc",  64'(next_pc), 64'h104);

    // 3: multiply holds PC exactly 4 cycles
    do_reset();
    pc_out = 32'h20; mul_start = 1'b1;
    #1;
    check_val("mul_nextpc", 64'(next_pc), 64'h24);
    check_val("mul_halt0",  64'(pc_halt), 64'd0);
    @(negedge clk);
    pc_out = 32'h24;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_val("mulw_state",  64'(state),   64'd1);
      check_val("mulw_halt",   64'(pc_halt), 64'd1);
      check_val("mulw_nextpc", 64'(next_pc), 64'h24);
      @(negedge clk);
      if (k == 3) mul_start = 1'b0;
    end
    #1;
    check_val("mul_done_state", 64'(state),       64'd0);
    check_val("mul_done_halt",  64'(pc_halt),     64'd0);
    check_val("mul_stall_cnt",  64'(stall_count), 64'd4);
    check_val("mul_cycle_cnt",  64'(cycle_count), 64'd1);

    // 4: syscall halt drops the branch, holds, then resumes
    do_reset();
    pc_out = 32'h30; syscall_halt = 1'b1;
    branch_taken = 1'b1; branch_target = 32'h80;
    #1;
    check_val("sys_flush", 64'(flush),   64'd0);
    check_val("sys_halt",  64'(pc_halt), 64'd1);
    @(negedge clk);
    clear_inputs();
    check_val("sys_state", 64'(state), 64'd2);
    for (int k = 0; k < 10; k++) begin
      #1;
      check_val("hlt_halt",   64'(pc_halt), 64'd1);
      check_val("hlt_nextpc", 64'(next_pc), 64'h30);
      @(negedge clk);
    end
    check_val("hlt_stall_cnt", 64'(stall_count), 64'd1);
    check_val("hlt_cycle_cnt", 64'(cycle_count), 64'd0);
    resume = 1'b1;
    #1;
    check_val("res_halt", 64'(pc_halt), 64'd1);
    @(negedge clk);
    resume = 1'b0;
    #1;
    check_val("res_state",  64'(state),   64'd0);
    check_val("res_nextpc", 64'(next_pc), 64'h34);
    check_val("res_halt1",  64'(pc_halt), 64'd0);
    @(negedge clk);

    // 5: hazard stall, then jump overriding it
    pc_out = 32'h50; hazard_stall = 1'b1;
    #1;
    check_val("haz_halt",   64'(pc_halt), 64'd1);
    check_val("haz_nextpc", 64'(next_pc), 64'h50);
    check_val("haz_flush",  64'(flush),   64'd0);
    @(negedge clk);
    jump = 1'b1; jump_target = 32'h200;
    #1;
    check_val("hazj_halt",   64'(pc_halt), 64'd0);
    check_val("hazj_nextpc", 64'(next_pc), 64'h200);
    check_val("hazj_flush",  64'(flush),   64'd1);
    @(negedge clk);
    clear_inputs();

    // 6: async reset in MULWAIT, then counter wrap
    do_reset();
    pc_out = 32'h60; mul_start = 1'b1;
    @(negedge clk);
    mul_start = 1'b0;
    @(negedge clk);
    check_val("mrst_pre_state", 64'(state),       64'd1);
    check_val("mrst_pre_stall", 64'(stall_count), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check_val("mrst_state",  64'(state),       64'd0);
    check_val("mrst_cycle",  64'(cycle_count), 64'd0);
    check_val("mrst_stall",  64'(stall_count), 64'd0);
    check_val("mrst_nextpc", 64'(next_pc),     64'(RVEC));
    check_val("mrst_halt",   64'(pc_halt),     64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("mrst_rel_halt", 64'(pc_halt), 64'd0);
    for (int i = 0; i < 255; i++) @(negedge clk);
    check_val("wrap_pre",  64'(cycle_count), 64'd255);
    @(negedge clk);
    check_val("wrap_zero", 64'(cycle_count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
